// File: rtl/mux_nto1_seq_pkg.sv
// Shared types and helpers for the sequential N-to-1 lane selector.
// Provides the controller state encoding and a generic lane-extraction function.
package mux_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        LAST = 2'd2
    } state_t;

    localparam int LANE_MAX_N   = 256;
    localparam int LANE_MAX_W   = 32;
    localparam int LANE_BUS_MAX = LANE_MAX_N * LANE_MAX_W;

    // Returns lane idx of a packed bus (lane width w, n lanes), or zero when idx is out of range
    function automatic logic [LANE_MAX_W-1:0] lane_sel(
        input logic [LANE_BUS_MAX-1:0] x,
        input int                      idx,
        input int                      n,
        input int                      w
    );
        logic [LANE_MAX_W-1:0] r;
        logic [12:0]           pos;
        r = {LANE_MAX_W{1'b0}};
        for (int b = 0; b < LANE_MAX_W; b++) begin
            pos = 13'(idx * w + b);
            if (idx < n && b < w) begin
                r[b] = x[pos];
            end else begin
                r[b] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_lane_sel.sv
// Combinational N*W -> W lane selector built from per-lane masks.
// A select code with no matching lane yields an all-zero result.
module mux_lane_sel #(
    parameter int N  = 32,
    parameter int W  = 1,
    parameter int SW = $clog2(N)
) (
    input  logic [N*W-1:0] x,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   y
);

    logic [W-1:0] masked [N];

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign masked[i] = (sel == SW'(i)) ? x[i*W +: W] : {W{1'b0}};
    end

    // OR-reduce the masked lanes; at most one is non-zero
    always_comb begin
        y = {W{1'b0}};
        for (int k = 0; k < N; k++) begin
            y = y | masked[k];
        end
    end

endmodule

// File: rtl/mux_nto1_seq.sv
// Registered N-to-1 lane selector with manual requests and a hardware sweep mode.
// Optional macro MUX_SEL_RANGE_EN adds a registered sel_err flag for out-of-range manual selects.
module mux_nto1_seq
    import mux_seq_pkg::*;
#(
    parameter int N  = 32,
    parameter int W  = 1,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] x,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [SW-1:0]  req_sel,
    input  logic           scan_start,
    output logic           busy,
    output logic           done,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   y,
    output logic [SW-1:0]  y_sel
`ifdef MUX_SEL_RANGE_EN
    ,
    output logic           sel_err
`endif
);

    state_t        state_r, state_n_s;
    logic [SW-1:0] cnt_r, cnt_n_s, sel_s;
    logic          load_s, load_en_s, done_n_s;
    logic [W-1:0]  lane_s;
    logic          out_valid_r, busy_r, done_r;
    logic [W-1:0]  y_r;
    logic [SW-1:0] y_sel_r;
`ifdef MUX_SEL_RANGE_EN
    logic          err_n_s, sel_err_r;
`endif

    mux_lane_sel #(.N(N), .W(W), .SW(SW)) u_lane_sel (
        .x   (x),
        .sel (sel_s),
        .y   (lane_s)
    );

    assign load_s = ~out_valid_r | out_ready;

    // Next-state, scan counter and load decision; scan_start outranks a same-cycle request
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        sel_s     = req_sel;
        req_ready = 1'b0;
        load_en_s = 1'b0;
        done_n_s  = 1'b0;
`ifdef MUX_SEL_RANGE_EN
        err_n_s   = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (scan_start) begin
                    state_n_s = SCAN;
                    cnt_n_s   = {SW{1'b0}};
                end else begin
                    req_ready = load_s;
                    load_en_s = req_valid & load_s;
`ifdef MUX_SEL_RANGE_EN
                    err_n_s   = ({1'b0, req_sel} >= (SW+1)'(N));
`endif
                end
            end
            SCAN: begin
                sel_s = cnt_r;
                if (load_s) begin
                    load_en_s = 1'b1;
                    if (cnt_r == SW'(N - 1)) begin
                        state_n_s = LAST;
                        cnt_n_s   = {SW{1'b0}};
                    end else begin
                        cnt_n_s = cnt_r + SW'(1);
                    end
                end else begin
                    cnt_n_s = cnt_r;
                end
            end
            LAST: begin
                if (out_valid_r && out_ready) begin
                    state_n_s = IDLE;
                    done_n_s  = 1'b1;
                end else begin
                    state_n_s = LAST;
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // Controller state and single-entry output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {SW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            out_valid_r <= 1'b0;
            y_r         <= {W{1'b0}};
            y_sel_r     <= {SW{1'b0}};
`ifdef MUX_SEL_RANGE_EN
            sel_err_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
            busy_r  <= (state_n_s != IDLE);
            done_r  <= done_n_s;
            if (load_en_s) begin
                out_valid_r <= 1'b1;
                y_r         <= lane_s;
                y_sel_r     <= sel_s;
`ifdef MUX_SEL_RANGE_EN
                sel_err_r   <= err_n_s;
`endif
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign out_valid = out_valid_r;
    assign y         = y_r;
    assign y_sel     = y_sel_r;
`ifdef MUX_SEL_RANGE_EN
    assign sel_err   = sel_err_r;
`endif

endmodule

// File: tb/tb_mux_nto1_seq.sv
// Scoreboard bench for mux_nto1_seq: stimulus pushes expected beats, a monitor pops on each handshake.
// With MUX_SEL_RANGE_EN the bench uses N=24, W=8 and also checks sel_err.
module tb_mux_nto1_seq;

`ifdef MUX_SEL_RANGE_EN
    localparam int N = 24;
    localparam int W = 8;
`else
    localparam int N = 32;
    localparam int W = 1;
`endif
    localparam int SW = $clog2(N);

    typedef struct packed {
        logic [W-1:0]  y;
        logic [SW-1:0] sel;
        logic          err;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] x;
    logic           req_valid, req_ready, scan_start, busy, done, out_valid, out_ready;
    logic [SW-1:0]  req_sel, y_sel;
    logic [W-1:0]   y;
`ifdef MUX_SEL_RANGE_EN
    logic           sel_err;
`endif

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   beats = 0;
    int   done_cnt = 0;

    mux_nto1_seq #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x          (x),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sel    (req_sel),
        .scan_start (scan_start),
        .busy       (busy),
        .done       (done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .y_sel      (y_sel)
`ifdef MUX_SEL_RANGE_EN
        ,
        .sel_err    (sel_err)
`endif
    );

    always #5 clk = ~clk;

    // Lane contents: 0xAAAAAAAA pattern (odd lanes 1) or lane i = i+0x10 for the wide build
    function automatic logic [W-1:0] exp_y(input int i);
`ifdef MUX_SEL_RANGE_EN
        if (i < N) return W'(i + 16);
        return {W{1'b0}};
`else
        return W'(i % 2);
`endif
    endfunction

    function automatic logic exp_err(input int i);
        return (i >= N);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: every handshake must match the oldest expected beat
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_chk++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got y=%0h y_sel=%0d expected no beat", y, y_sel);
            end else begin
                mon_e = sb_q.pop_front();
`ifdef MUX_SEL_RANGE_EN
                if (y !== mon_e.y || y_sel !== mon_e.sel || sel_err !== mon_e.err) begin
                    n_fail++;
                    $display("FAIL beat: got y=%0h y_sel=%0d err=%0b expected y=%0h y_sel=%0d err=%0b",
                             y, y_sel, sel_err, mon_e.y, mon_e.sel, mon_e.err);
                end
`else
                if (y !== mon_e.y || y_sel !== mon_e.sel) begin
                    n_fail++;
                    $display("FAIL beat: got y=%0h y_sel=%0d expected y=%0h y_sel=%0d",
                             y, y_sel, mon_e.y, mon_e.sel);
                end
`endif
            end
            beats++;
        end
        if (rst_n && done) done_cnt++;
    end

    task automatic do_req(input int sel);
        bit got;
        got = 1'b0;
        req_valid = 1'b1;
        req_sel   = SW'(sel);
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                sb_q.push_back(exp_t'{exp_y(sel), SW'(sel), exp_err(sel)});
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("req_accepted", 32'(got), 32'd1);
        chk("req_latency", 32'(out_valid), 32'd1);
    endtask

    task automatic push_sweep();
        for (int i = 0; i < N; i++) sb_q.push_back(exp_t'{exp_y(i), SW'(i), 1'b0});
    endtask

    task automatic start_scan();
        push_sweep();
        scan_start = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
        chk("busy_on", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string name, input bit toggle);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk); #1;
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #1;
                if (toggle) begin
                    out_ready  = ~out_ready;
                    scan_start = (c == 10);
                end
            end
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
        out_ready  = 1'b1;
        scan_start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int b0, d0;
        rst_n = 1'b0; req_valid = 1'b0; req_sel = '0; scan_start = 1'b0; out_ready = 1'b1;
`ifdef MUX_SEL_RANGE_EN
        for (int i = 0; i < N; i++) x[i*W +: W] = W'(i + 16);
`else
        x = 32'hAAAA_AAAA;
`endif
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_y_sel", 32'(y_sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        // Manual requests with a free-running consumer
        do_req(0);
        do_req(1);
        do_req(N - 1);
`ifdef MUX_SEL_RANGE_EN
        do_req(30);
        do_req(5);
`endif
        repeat (2) @(posedge clk); #1;

        // Backpressure holds the result and blocks the next request
        out_ready = 1'b0;
        do_req(5);
        req_valid = 1'b1; req_sel = SW'(2);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_y", 32'(y), 32'(exp_y(5)));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("handshake_req_ready", 32'(req_ready), 32'd1);
        sb_q.push_back(exp_t'{exp_y(2), SW'(2), 1'b0});
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("manual_drained", 32'(sb_q.size()), 32'd0);

        // Full sweep, consumer always ready
        b0 = beats; d0 = done_cnt;
        start_scan();
        wait_done("scan", 1'b0);
        chk("scan_beats", 32'(beats - b0), 32'(N));
        chk("scan_done_once", 32'(done_cnt - d0), 32'd1);
        chk("scan_busy_after", 32'(busy), 32'd0);

        // Sweep with toggling backpressure and an ignored mid-sweep start
        b0 = beats; d0 = done_cnt;
        start_scan();
        wait_done("toggle", 1'b1);
        chk("toggle_beats", 32'(beats - b0), 32'(N));
        chk("toggle_done_once", 32'(done_cnt - d0), 32'd1);
        chk("toggle_drained", 32'(sb_q.size()), 32'd0);

        // scan_start beats a same-cycle request, then reset mid-sweep at beat 10
        push_sweep();
        b0 = beats;
        scan_start = 1'b1; req_valid = 1'b1; req_sel = SW'(3);
        @(negedge clk);
        chk("start_priority_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        scan_start = 1'b0; req_valid = 1'b0;
        chk("start_priority_busy", 32'(busy), 32'd1);
        for (int c = 0; c < 100 && (beats - b0) < 10; c++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        chk("pre_reset_y_sel", 32'(y_sel), 32'd10);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_y", 32'(y), 32'd0);
        chk("async_rst_y_sel", 32'(y_sel), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        sb_q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        b0 = beats;
        start_scan();
        wait_done("post_reset", 1'b0);
        chk("post_reset_beats", 32'(beats - b0), 32'(N));
        chk("post_reset_drained", 32'(sb_q.size()), 32'd0);

        #20;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
